// File: rtl/carry_lookahead_adder_if.sv
// Operand/result bundle for the registered carry-lookahead adder.
// The master drives the operands and carry-in. The slave (the adder) returns
// the registered sum and carry-out.
interface carry_lookahead_adder_if #(
  parameter int WIDTH = 9
);
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             carry_in;
  logic [WIDTH-1:0] z;
  logic             carry_out;

  modport master (
    output x,
    output y,
    output carry_in,
    input  z,
    input  carry_out
  );

  modport slave (
    input  x,
    input  y,
    input  carry_in,
    output z,
    output carry_out
  );
endinterface

// File: rtl/carry_lookahead_adder.sv
// Registered WIDTH-bit adder with a two-level carry-lookahead network.
// Each bit produces its own generate and propagate signals. GROUP-bit blocks
// expand their internal carries as sums of products from the block carry-in.
// A group-level unit works out every block carry-in, and the final carry-out,
// directly from the block (G, P) pairs and carry_in.
// The sum and carry-out registers load on every rising clk edge.
module carry_lookahead_adder #(
  parameter int WIDTH = 9,
  parameter int GROUP = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  carry_lookahead_adder_if.slave bus
);

  // Number of lookahead blocks. The top block may be partial.
  localparam int NB = (WIDTH + GROUP - 1) / GROUP;
  // The shared lookahead function works on vectors wide enough for
  // either level.
  localparam int FW = (WIDTH > GROUP) ? WIDTH : GROUP;

  // Carry into position n of a (g, p) chain, written in flat
  // sum-of-products form:
  //   cin & p[0..n-1]  |  OR over j<n of ( g[j] & p[j+1..n-1] )
  // At every call site, n is an elaboration-time constant. The loops
  // therefore unroll into one AND-OR level with no ripple path.
  function automatic logic carry_sop(
    input logic [FW-1:0] gv,
    input logic [FW-1:0] pv,
    input int            n,
    input logic          cin
  );
    logic acc;
    logic term;
    acc = 1'b0;
    for (int j = 0; j < FW; j++) begin
      if (j < n) begin
        term = gv[j];
        for (int k = 0; k < FW; k++) begin
          if (k > j && k < n) begin
            term = term & pv[k];
          end
        end
        acc = acc | term;
      end
    end
    term = cin;
    for (int k = 0; k < FW; k++) begin
      if (k < n) begin
        term = term & pv[k];
      end
    end
    return acc | term;
  endfunction

  logic [WIDTH-1:0] g;          // per-bit generate
  logic [WIDTH-1:0] p;          // per-bit propagate
  logic [WIDTH:0]   c;          // carry into each bit, c[WIDTH] = carry out
  logic [FW-1:0]    grp_g;      // block generate, padded beyond NB
  logic [FW-1:0]    grp_p;      // block propagate, padded beyond NB
  logic [NB-1:0]    blk_cin;    // carry into each block
  logic [WIDTH-1:0] z_next;
  logic             carry_out_next;
  logic [WIDTH-1:0] z_reg;
  logic             carry_out_reg;

  assign g = bus.x & bus.y;
  assign p = bus.x ^ bus.y;

  // Group-level padding: unused slots never generate and always propagate,
  // so they cannot disturb the lookahead terms.
  genvar gi;
  generate
    for (gi = NB; gi < FW; gi++) begin : g_grp_pad
      assign grp_g[gi] = 1'b0;
      assign grp_p[gi] = 1'b1;
    end
  endgenerate

  generate
    for (gi = 0; gi < NB; gi++) begin : g_block
      localparam int BASE = gi * GROUP;
      localparam int LEN  = ((WIDTH - BASE) < GROUP) ? (WIDTH - BASE) : GROUP;

      logic [FW-1:0] bg;
      logic [FW-1:0] bp;

      // Gather this block's bits. A partial block is padded with
      // non-generating, propagating bits, so its G and P come out right.
      for (genvar gk = 0; gk < FW; gk++) begin : g_bit
        if (gk < LEN) begin : g_real
          assign bg[gk] = g[BASE + gk];
          assign bp[gk] = p[BASE + gk];
        end else begin : g_pad
          assign bg[gk] = 1'b0;
          assign bp[gk] = 1'b1;
        end
      end

      // Block terms for the group-level unit.
      assign grp_g[gi] = carry_sop(bg, bp, FW, 1'b0);
      assign grp_p[gi] = &bp;

      // Block carry-in, taken from all lower blocks and carry_in.
      assign blk_cin[gi] = carry_sop(grp_g, grp_p, gi, bus.carry_in);
      assign c[BASE]     = blk_cin[gi];

      // Internal carries, expanded from the block carry-in.
      for (genvar gk = 1; gk < LEN; gk++) begin : g_inner
        assign c[BASE + gk] = carry_sop(bg, bp, gk, blk_cin[gi]);
      end
    end
  endgenerate

  // The carry-out is one more lookahead step past the top block.
  assign c[WIDTH] = carry_sop(grp_g, grp_p, NB, bus.carry_in);

  assign z_next         = p ^ c[WIDTH-1:0];
  assign carry_out_next = c[WIDTH];

  // Result registers: cleared at once by reset, otherwise loaded every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_reg         <= '0;
      carry_out_reg <= 1'b0;
    end else begin
      z_reg         <= z_next;
      carry_out_reg <= carry_out_next;
    end
  end

  assign bus.z         = z_reg;
  assign bus.carry_out = carry_out_reg;

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Bench for carry_lookahead_adder: a 9-bit/4-group and a 16-bit/3-group
// instance run side by side. A plain-arithmetic reference, delayed by one
// clock, is compared against both every cycle. Directed literal cases pin
// the corner behaviour.
module tb_carry_lookahead_adder;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  bit   chk_en;

  carry_lookahead_adder_if #(.WIDTH(9))  if9 ();
  carry_lookahead_adder_if #(.WIDTH(16)) if16 ();

  carry_lookahead_adder #(.WIDTH(9), .GROUP(4)) u_dut9 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if9)
  );

  carry_lookahead_adder #(.WIDTH(16), .GROUP(3)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16)
  );

  initial clk = 1'b0;
  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Reference: the exact (WIDTH+1)-bit sum of the inputs at the last edge,
  // forced to zero while reset is low.
  logic [9:0]  exp9;
  logic [16:0] exp16;
  // Model state update on the same events as the design's registers.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp9  <= '0;
      exp16 <= '0;
    end else begin
      exp9  <= {1'b0, if9.x}  + {1'b0, if9.y}  + 10'(if9.carry_in);
      exp16 <= {1'b0, if16.x} + {1'b0, if16.y} + 17'(if16.carry_in);
    end
  end

  function automatic void check(input string nm, input logic [16:0] act,
                                input logic [16:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endfunction

  // Compare both instances against the reference, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model9",  {7'd0, if9.carry_out, if9.z},  {7'd0, exp9});
      check("model16", {if16.carry_out, if16.z}, exp16);
    end
  end

  task automatic run9(input logic [8:0] a, input logic [8:0] b, input logic ci,
                      input logic [9:0] req, input string nm);
    @(negedge clk);
    if9.x = a; if9.y = b; if9.carry_in = ci;
    @(posedge clk);
    #1;
    check(nm, {7'd0, if9.carry_out, if9.z}, {7'd0, req});
    $display("[TB] %s: x=%h y=%h ci=%0d -> co=%0d z=%h", nm, a, b, ci,
             if9.carry_out, if9.z);
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input logic [16:0] req, input string nm);
    @(negedge clk);
    if16.x = a; if16.y = b; if16.carry_in = ci;
    @(posedge clk);
    #1;
    check(nm, {if16.carry_out, if16.z}, req);
    $display("[TB] %s: x=%h y=%h ci=%0d -> co=%0d z=%h", nm, a, b, ci,
             if16.carry_out, if16.z);
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    if9.x  = '0; if9.y  = '0; if9.carry_in  = 1'b0;
    if16.x = '0; if16.y = '0; if16.carry_in = 1'b0;

    // Reset state before any clock edge, then across an edge while held.
    #2;
    check("reset9_t0",  {7'd0, if9.carry_out, if9.z},  17'd0);
    check("reset16_t0", {if16.carry_out, if16.z}, 17'd0);
    if9.x = 9'h1FF; if9.y = 9'h1FF; if9.carry_in = 1'b1;
    @(posedge clk); #1;
    check("reset9_held", {7'd0, if9.carry_out, if9.z}, 17'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Directed cases with hand-computed results.
    run9(9'h003, 9'h005, 1'b0, 10'h008, "add_3_5");
    run9(9'h000, 9'h005, 1'b0, 10'h005, "add_0_5");
    run9(9'h000, 9'h005, 1'b1, 10'h006, "add_0_5_ci");
    run9(9'h0C0, 9'h040, 1'b1, 10'h101, "block_carry");
    run9(9'h1FF, 9'h000, 1'b1, 10'h200, "wrap_to_zero");
    run9(9'h1FF, 9'h1FF, 1'b1, 10'h3FF, "max_inputs");
    run16(16'hFFFF, 16'h0000, 1'b1, 17'h10000, "w16_wrap");
    run16(16'h1234, 16'h0FED, 1'b1, 17'h02222, "w16_mixed");
    run16(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, "w16_max");

    // Asynchronous reset between edges while z is non-zero.
    @(negedge clk);
    if9.x = 9'h0A0; if9.y = 9'h011; if9.carry_in = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", {7'd0, if9.carry_out, if9.z}, 17'd0);
    #1;
    rst_n = 1'b1;
    #0.5;
    check("hold_after_release", {7'd0, if9.carry_out, if9.z}, 17'd0);
    @(posedge clk); #1;
    check("first_edge_load", {7'd0, if9.carry_out, if9.z}, 17'h000B2);
    $display("[TB] reset mid-stream: co=%0d z=%h", if9.carry_out, if9.z);

    // Back-to-back random traffic on both instances. Corner operands are
    // mixed in now and then.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      case ($urandom_range(0, 7))
        0: begin if9.x = 9'h1FF; if9.y = 9'($urandom()); end
        1: begin if9.x = 9'($urandom()); if9.y = ~if9.x; end
        default: begin if9.x = 9'($urandom()); if9.y = 9'($urandom()); end
      endcase
      if9.carry_in = 1'($urandom());
      if ($urandom_range(0, 7) == 0) begin
        if16.x = 16'hFFFF;
        if16.y = 16'($urandom_range(0, 1));
      end else begin
        if16.x = 16'($urandom());
        if16.y = 16'($urandom());
      end
      if16.carry_in = 1'($urandom());
      $display("[TB] rand %0d: x9=%h y9=%h ci9=%0d x16=%h y16=%h ci16=%0d", i,
               if9.x, if9.y, if9.carry_in, if16.x, if16.y, if16.carry_in);
    end
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
